// File: rtl/if_id_pipe_buf.sv
// IF/ID pipeline buffer: DEPTH-entry in-order queue with valid/ready handshake,
// single-cycle flush and saturating stall/flush performance counters.
module if_id_pipe_buf #(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned FIELDS = 3,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_W*FIELDS-1:0]    in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W*FIELDS-1:0]    out_data,
    output logic [$clog2(DEPTH):0]      occupancy,
    output logic [CNT_W-1:0]            stall_cnt,
    output logic [CNT_W-1:0]            flush_cnt
);

    localparam int unsigned DATA_W = WORD_W * FIELDS;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned OCC_W  = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [OCC_W-1:0]  count_q,     count_d;
    logic              in_ready_q,  in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [CNT_W-1:0]  stall_q,     stall_d;
    logic [CNT_W-1:0]  flushc_q,    flushc_d;

    logic push_c;
    logic pop_c;

    assign push_c = in_valid  & in_ready_q & ~flush;
    assign pop_c  = out_valid_q & out_ready & ~flush;

    // Next-state: pointers, count, registered handshake flags and head payload.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        stall_d     = stall_q;
        flushc_d    = flushc_q;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        out_data_d  = '0;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = PTR_W'(wr_ptr_q + 1'b1);
            end
            if (pop_c) begin
                rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = OCC_W'(count_q + 1'b1);
                2'b01:   count_d = OCC_W'(count_q - 1'b1);
                default: count_d = count_q;
            endcase
        end

        in_ready_d  = (count_d != OCC_FULL);
        out_valid_d = (count_d != '0);

        // The entry being written this cycle becomes head only when it is the sole entry.
        if (count_d != '0) begin
            if (push_c && (wr_ptr_q == rd_ptr_d)) begin
                out_data_d = in_data;
            end else begin
                out_data_d = mem_q[rd_ptr_d];
            end
        end

        if (out_valid_q && !out_ready && !flush && (stall_q != '1)) begin
            stall_d = CNT_W'(stall_q + 1'b1);
        end
        if (flush && ((count_q != '0) || in_valid) && (flushc_q != '1)) begin
            flushc_d = CNT_W'(flushc_q + 1'b1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            stall_q     <= '0;
            flushc_q    <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            stall_q     <= stall_d;
            flushc_q    <= flushc_d;
        end
    end

    // Payload storage is never cleared; only pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (!RST && push_c) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign occupancy = count_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flushc_q;

endmodule

// File: tb/tb_if_id_pipe_buf.sv
// Directed bench for if_id_pipe_buf: a DEPTH=2 instance for handshake/flush
// scenarios and a DEPTH=4, CNT_W=4 instance for wrap-around and saturation.
module tb_if_id_pipe_buf;

    logic CLK = 1'b0;
    logic RST;

    logic        flush0, iv0, ir0, ov0, or0;
    logic [95:0] id0, od0;
    logic [1:0]  occ0;
    logic [15:0] sc0, fc0;

    logic        flush1, iv1, ir1, ov1, or1;
    logic [95:0] id1, od1;
    logic [2:0]  occ1;
    logic [3:0]  sc1, fc1;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    if_id_pipe_buf #(.WORD_W(32), .FIELDS(3), .DEPTH(2), .CNT_W(16)) dut0 (
        .CLK(CLK), .RST(RST), .flush(flush0),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .occupancy(occ0), .stall_cnt(sc0), .flush_cnt(fc0)
    );

    if_id_pipe_buf #(.WORD_W(32), .FIELDS(3), .DEPTH(4), .CNT_W(4)) dut1 (
        .CLK(CLK), .RST(RST), .flush(flush1),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .occupancy(occ1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {curr_pc, npc, instr}: field 0 (instr) in the low word
    function automatic logic [95:0] mk(input int i);
        logic [31:0] pc;
        pc = 32'h1000 + 32'(i) * 32'd4;
        return {pc, pc + 32'd4, 32'hC0DE0000 + 32'(i)};
    endfunction

    localparam logic [95:0] P1 = {32'h0, 32'h4, 32'h00000013};
    localparam logic [95:0] P2 = {32'h4, 32'h8, 32'h00A00093};
    localparam logic [95:0] PA = {32'h10, 32'h14, 32'hAAAA0001};
    localparam logic [95:0] PB = {32'h14, 32'h18, 32'hBBBB0002};
    localparam logic [95:0] PC = {32'h18, 32'h1C, 32'hCCCC0003};
    localparam logic [95:0] PD = {32'h20, 32'h24, 32'hDDDD0004};
    localparam logic [95:0] PE = {32'h24, 32'h28, 32'hEEEE0005};

    initial begin
        logic [95:0] q[$];
        int sent, got, mcount, mstall;
        bit push, pop;

        RST = 1'b1;
        flush0 = 1'b0; iv0 = 1'b1; or0 = 1'b0; id0 = {3{32'hAAAAAAAA}};
        flush1 = 1'b0; iv1 = 1'b0; or1 = 1'b0; id1 = '0;

        // Reset with in_valid held high
        step();
        step();
        RST = 1'b0; iv0 = 1'b0;
        chk("rst_in_ready", ir0, 1);
        chk("rst_out_valid", ov0, 0);
        chk("rst_out_data", od0, 0);
        chk("rst_occ", occ0, 0);
        chk("rst_stall", sc0, 0);
        chk("rst_flush", fc0, 0);
        chk("rst_occ1", occ1, 0);
        chk("rst_in_ready1", ir1, 1);
        step();
        chk("rst_nothing_enq", occ0, 0);

        // Streaming
        or0 = 1'b1; iv0 = 1'b1; id0 = P1;
        step();
        chk("str_v1", ov0, 1);
        chk("str_d1", od0, P1);
        chk("str_occ1", occ0, 1);
        id0 = P2;
        step();
        chk("str_d2", od0, P2);
        chk("str_occ2", occ0, 1);
        iv0 = 1'b0;
        step();
        chk("str_empty", ov0, 0);
        chk("str_empty_data", od0, 0);
        chk("str_stall0", sc0, 0);

        // Fill / stall
        or0 = 1'b0; iv0 = 1'b1; id0 = PA;
        step();
        chk("fill_ready_a", ir0, 1);
        id0 = PB;
        step();
        chk("fill_ready_b", ir0, 0);
        chk("fill_occ", occ0, 2);
        chk("fill_head", od0, PA);
        chk("fill_stall1", sc0, 1);
        id0 = PC;
        step();
        chk("fill_occ_c", occ0, 2);
        chk("fill_stall2", sc0, 2);
        step();
        chk("fill_stall3", sc0, 3);
        chk("fill_head_a", od0, PA);
        or0 = 1'b1;
        step();
        chk("drain_b", od0, PB);
        chk("drain_occ", occ0, 1);
        chk("drain_ready", ir0, 1);
        chk("drain_stall", sc0, 3);
        step();
        chk("drain_c", od0, PC);
        iv0 = 1'b0;
        step();
        chk("drain_empty", ov0, 0);
        chk("drain_occ0", occ0, 0);

        // Flush with simultaneous push/pop attempt on a full buffer
        or0 = 1'b0; iv0 = 1'b1; id0 = mk(1);
        step();
        id0 = mk(2);
        step();
        chk("fl_pre_occ", occ0, 2);
        chk("fl_pre_stall", sc0, 4);
        or0 = 1'b1; id0 = PD; flush0 = 1'b1;
        step();
        flush0 = 1'b0;
        chk("fl_occ", occ0, 0);
        chk("fl_valid", ov0, 0);
        chk("fl_data", od0, 0);
        chk("fl_cnt", fc0, 1);
        chk("fl_ready", ir0, 1);
        chk("fl_stall", sc0, 4);
        or0 = 1'b0; id0 = PE;
        step();
        iv0 = 1'b0;
        chk("fl_e_data", od0, PE);
        chk("fl_e_occ", occ0, 1);
        or0 = 1'b1;
        step();
        chk("fl_e_alone", ov0, 0);

        // Flush drops an input that would otherwise have been accepted
        or0 = 1'b0; iv0 = 1'b1; id0 = mk(3);
        step();
        flush0 = 1'b1; id0 = mk(4);
        step();
        flush0 = 1'b0; iv0 = 1'b0;
        chk("fl2_occ", occ0, 0);
        chk("fl2_cnt", fc0, 2);
        step();
        chk("fl2_dropped", occ0, 0);
        flush0 = 1'b1;
        step();
        flush0 = 1'b0;
        chk("fl3_idle_cnt", fc0, 2);

        // Wrap-around on DEPTH=4 with random out_ready
        sent = 0; got = 0; mcount = 0; mstall = 0;
        for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
            iv1 = (sent < 10);
            id1 = mk(100 + sent);
            or1 = 1'($urandom_range(0, 1));
            chk("wr_ready", ir1, (mcount != 4));
            chk("wr_valid", ov1, (mcount != 0));
            chk("wr_occ", occ1, 128'(mcount));
            chk("wr_stall", sc1, 128'(mstall));
            if (mcount != 0) chk("wr_data", od1, q[0]);
            push = iv1 && (mcount != 4);
            pop  = or1 && (mcount != 0);
            if (mcount != 0 && !or1 && mstall < 15) mstall++;
            if (pop) begin
                void'(q.pop_front());
                got++;
                mcount--;
            end
            if (push) begin
                q.push_back(id1);
                sent++;
                mcount++;
            end
            step();
        end
        iv1 = 1'b0; or1 = 1'b0;
        chk("wr_all_received", 128'(got), 10);
        chk("wr_final_occ", occ1, 0);

        // Stall counter saturation on CNT_W=4
        iv1 = 1'b1; id1 = mk(20);
        step();
        iv1 = 1'b0;
        repeat (20) step();
        chk("sat_stall", sc1, 15);
        chk("sat_head", od1, mk(20));
        repeat (3) step();
        chk("sat_hold", sc1, 15);
        chk("sat_flushcnt", fc1, 0);

        // Mid-operation reset clears entries and counters
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rst2_stall1", sc1, 0);
        chk("rst2_occ1", occ1, 0);
        chk("rst2_valid1", ov1, 0);
        chk("rst2_stall0", sc0, 0);
        chk("rst2_flush0", fc0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
